block_xfer_ctrl: RTL and testbench

Sequencer that shares the CPU register file's read and write ports with the data-memory interface to execute ARM-style block transfers. LDM loads consecutive words into listed registers; STM stores listed registers to consecutive words. It sits beside the execute stage, owns the register-file port addresses while busy, and hands control back on completion.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/block_xfer_ctrl_if.sv | 34 +++
 rtl/lowest_set_enc16.sv | 24 ++
 rtl/block_xfer_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_block_xfer_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the block-transfer sequencer: register-file
// geometry, word size, sequencer state encoding and a mask popcount helper.
// No ports. BLOCK_XFER_WB_EN adds the base-register write-back state.
package cpu_pkg;

  localparam int REG_AW     = 4;
  localparam int WORD_BYTES = 4;
  localparam int NUM_REGS   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
`ifdef BLOCK_XFER_WB_EN
    ST_WB   = 2'd2,
`endif
    ST_DONE = 2'd3
  } xfer_state_t;

  // Number of registers named in a transfer mask.
  function automatic logic [4:0] popcount16(input logic [NUM_REGS-1:0] m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      n = n + 5'(m[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/block_xfer_ctrl_if.sv
// Register-file and data-memory port bundle owned by the block-transfer
// sequencer. master = sequencer side (drives addresses, strobes, store data),
// slave = register file / memory side (returns read data, mem_ack, load data).
interface block_xfer_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = cpu_pkg::REG_AW
);

  logic [REG_AW-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic [REG_AW-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic              rf_write_enable;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output rf_read_addr, rf_write_addr, rf_write_data, rf_write_enable,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  rf_read_data, mem_ack, mem_rdata
  );

  modport slave (
    input  rf_read_addr, rf_write_addr, rf_write_data, rf_write_enable,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output rf_read_data, mem_ack, mem_rdata
  );

endinterface

// File: rtl/lowest_set_enc16.sv
// Priority encoder: index of the lowest set bit of a 16-bit register mask.
// Ports: mask in; idx out (0 when mask is empty); vld out (mask non-zero).
// Purely combinational, no clock or reset.
module lowest_set_enc16
  import cpu_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  output logic [3:0]          idx,
  output logic                vld
);

  // Scan high to low so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 4'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_xfer_ctrl.sv
// LDM/STM sequencer: walks a register mask in ascending order, one memory word
// per register, sharing the register-file ports with the data-memory bus.
// Ports: clk, rst (async active-low), start/is_load/reg_list/base_addr/base_reg
// command, busy/done/end_addr status, bus = register-file + memory master.
// Optional macro BLOCK_XFER_WB_EN: writes end_addr to base_reg before done.
module block_xfer_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         is_load,
  input  logic [cpu_pkg::NUM_REGS-1:0] reg_list,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [REG_AW-1:0]            base_reg,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            end_addr,
  block_xfer_ctrl_if.master            bus
);

  cpu_pkg::xfer_state_t state;

  logic [cpu_pkg::NUM_REGS-1:0] mask_q;
  logic [cpu_pkg::NUM_REGS-1:0] mask_next;
  logic [ADDR_W-1:0]            addr_q;
  logic [ADDR_W-1:0]            end_addr_q;
  logic [ADDR_W-1:0]            accept_end;
  logic                         is_load_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         mem_req_q;
  logic                         mem_we_q;
  logic [3:0]                   idx;
  logic                         idx_vld;
  logic                         ack_take;
  logic                         last_xfer;

`ifdef BLOCK_XFER_WB_EN
  logic [REG_AW-1:0]            base_reg_q;
`else
  logic                         unused_base_reg;
  assign unused_base_reg = ^base_reg;
`endif

  lowest_set_enc16 u_enc (
    .mask (mask_q),
    .idx  (idx),
    .vld  (idx_vld)
  );

  // Remaining mask once the current register completes.
  assign mask_next = mask_q & ~(16'(1) << idx);
  assign last_xfer = (mask_next == '0);

  // Final address is known at accept time; the low two address bits are
  // dropped because every access is a whole word.
  assign accept_end = (base_addr & ~ADDR_W'(cpu_pkg::WORD_BYTES - 1))
                    + ADDR_W'(cpu_pkg::popcount16(reg_list)) * ADDR_W'(cpu_pkg::WORD_BYTES);

  // An ack only counts while a request is outstanding.
  assign ack_take = (state == cpu_pkg::ST_XFER) && bus.mem_ack && idx_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= cpu_pkg::ST_IDLE;
      mask_q     <= '0;
      addr_q     <= '0;
      end_addr_q <= '0;
      is_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
`ifdef BLOCK_XFER_WB_EN
      base_reg_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        cpu_pkg::ST_IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            mask_q     <= reg_list;
            addr_q     <= base_addr & ~ADDR_W'(cpu_pkg::WORD_BYTES - 1);
            end_addr_q <= accept_end;
            busy_q     <= 1'b1;
`ifdef BLOCK_XFER_WB_EN
            base_reg_q <= base_reg;
`endif
            if (reg_list != '0) begin
              state     <= cpu_pkg::ST_XFER;
              mem_req_q <= 1'b1;
              mem_we_q  <= ~is_load;
            end else begin
`ifdef BLOCK_XFER_WB_EN
              state  <= cpu_pkg::ST_WB;
`else
              state  <= cpu_pkg::ST_DONE;
              done_q <= 1'b1;
`endif
            end
          end
        end

        cpu_pkg::ST_XFER: begin
          // Without an ack everything holds, keeping the request stable.
          if (ack_take) begin
            mask_q <= mask_next;
            addr_q <= addr_q + ADDR_W'(cpu_pkg::WORD_BYTES);
            if (last_xfer) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
`ifdef BLOCK_XFER_WB_EN
              state     <= cpu_pkg::ST_WB;
`else
              state     <= cpu_pkg::ST_DONE;
              done_q    <= 1'b1;
`endif
            end
          end
        end

`ifdef BLOCK_XFER_WB_EN
        cpu_pkg::ST_WB: begin
          state  <= cpu_pkg::ST_DONE;
          done_q <= 1'b1;
        end
`endif

        cpu_pkg::ST_DONE: begin
          state  <= cpu_pkg::ST_IDLE;
          busy_q <= 1'b0;
        end

        default: begin
          state     <= cpu_pkg::ST_IDLE;
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign end_addr     = end_addr_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = addr_q;

  // Store data passes straight from the register file to memory, and load
  // data straight from memory into the register file on the ack cycle.
  always_comb begin
    bus.rf_read_addr    = '0;
    bus.mem_wdata       = '0;
    bus.rf_write_enable = 1'b0;
    bus.rf_write_addr   = '0;
    bus.rf_write_data   = '0;
    if (state == cpu_pkg::ST_XFER) begin
      if (!is_load_q) begin
        bus.rf_read_addr = REG_AW'(idx);
        bus.mem_wdata    = bus.rf_read_data;
      end else if (ack_take) begin
        bus.rf_write_enable = 1'b1;
        bus.rf_write_addr   = REG_AW'(idx);
        bus.rf_write_data   = bus.mem_rdata;
      end
    end
`ifdef BLOCK_XFER_WB_EN
    // Comes after every load write, so base_reg ends with the final address.
    if (state == cpu_pkg::ST_WB) begin
      bus.rf_write_enable = 1'b1;
      bus.rf_write_addr   = base_reg_q;
      bus.rf_write_data   = DATA_W'(end_addr_q);
    end
`endif
  end

endmodule

// File: tb/tb_block_xfer_ctrl.sv
// Bench for block_xfer_ctrl: acts as register file and data memory, drives
// directed and random LDM/STM transfers, and checks against a reference model.
// Ports: none (top-level bench). Honours BLOCK_XFER_WB_EN like the design.
module tb_block_xfer_ctrl;

`ifdef BLOCK_XFER_WB_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [15:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic [3:0]  base_reg = '0;
  logic        busy;
  logic        done;
  logic [31:0] end_addr;

  block_xfer_ctrl_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(4)) bus ();

  block_xfer_ctrl #(.DATA_W(32), .ADDR_W(32), .REG_AW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_load   (is_load),
    .reg_list  (reg_list),
    .base_addr (base_addr),
    .base_reg  (base_reg),
    .busy      (busy),
    .done      (done),
    .end_addr  (end_addr),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Register file model, written only by the DUT (plus one initial load).
  logic [31:0] regs [16];
  logic [31:0] ref_regs [16];
  logic [31:0] pre_regs [16];
  logic        init_req = 1'b0;
  logic [3:0]  wr_addr [$];
  logic [31:0] wr_data [$];

  assign bus.rf_read_data = regs[bus.rf_read_addr];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 16; i++) regs[i] <= ref_regs[i];
    end else if (bus.rf_write_enable) begin
      regs[bus.rf_write_addr] <= bus.rf_write_data;
      wr_addr.push_back(bus.rf_write_addr);
      wr_data.push_back(bus.rf_write_data);
    end
  end

  int checks = 0;
  int errors = 0;

  logic [31:0] acc_addr [$];
  logic [31:0] acc_data [$];
  logic        acc_we [$];
  int          done_cyc, stalls, unstable, busy_bad, req_cycles;
  bit          timeout;
  logic        start_busy;
  logic [140:0] snap;

  function automatic int popc(input logic [15:0] list);
    int k = 0;
    for (int i = 0; i < 16; i++) if (list[i]) k++;
    return k;
  endfunction

  function automatic logic [31:0] model_end(input logic [15:0] list, input logic [31:0] base);
    logic [31:0] a = base & 32'hFFFF_FFFC;
    return a + 32'(4 * popc(list));
  endfunction

  // Drive one transfer from accept to done, recording what the DUT did, then
  // advance the reference register model by the architectural effect.
  task automatic run_xfer(input logic ld, input logic [15:0] list, input logic [31:0] base,
                          input logic [3:0] breg, input int stall_at, input int stall_len,
                          input bit rnd, input bit noise);
    int c = 0, stall_left = 0, acc_i = 0, j = 0;
    bit stalled = 0, have_prev = 0, ack;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic p_we = 1'b0;
    acc_addr.delete(); acc_data.delete(); acc_we.delete();
    wr_addr.delete(); wr_data.delete();
    done_cyc = -1; stalls = 0; unstable = 0; busy_bad = 0; req_cycles = 0; timeout = 0;
    pre_regs = ref_regs;
    @(negedge clk);
    start_busy = busy;
    start = 1'b1; is_load = ld; reg_list = list; base_addr = base; base_reg = breg;
    @(posedge clk); #1;
    start = noise;
    while (done_cyc < 0 && !timeout) begin
      @(negedge clk);
      c++;
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) done_cyc = c;
      else if (c > 300) timeout = 1;
      if (bus.mem_req === 1'b1) begin
        req_cycles++;
        if (have_prev && (bus.mem_addr !== p_addr || bus.mem_wdata !== p_wdata || bus.mem_we !== p_we))
          unstable++;
        if (!stalled && acc_i == stall_at) begin stall_left = stall_len; stalled = 1; end
        if (stall_left > 0) begin ack = 0; stall_left--; end
        else ack = !(rnd && $urandom_range(0, 3) == 0);
        if (ack) begin
          acc_addr.push_back(bus.mem_addr); acc_data.push_back(bus.mem_wdata);
          acc_we.push_back(bus.mem_we); acc_i++; have_prev = 0;
        end else begin
          have_prev = 1; p_addr = bus.mem_addr; p_wdata = bus.mem_wdata; p_we = bus.mem_we; stalls++;
        end
        bus.mem_ack = ack;
        bus.mem_rdata = 32'hA5A5_0000 + bus.mem_addr;
      end else begin
        bus.mem_ack = rnd ? 1'($urandom) : 1'b0;
        bus.mem_rdata = $urandom;
      end
      if (noise && done_cyc < 0) begin
        is_load = 1'($urandom); reg_list = 16'($urandom);
        base_addr = $urandom; base_reg = 4'($urandom);
      end
    end
    start = 1'b0; bus.mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        if (ld) ref_regs[i] = 32'hA5A5_0000 + (base & 32'hFFFF_FFFC) + 32'(4 * j);
        j++;
      end
    end
`ifdef BLOCK_XFER_WB_EN
    ref_regs[breg] = model_end(list, base);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) ref_regs[i] = $urandom;
    #2 rst = 1'b0; init_req = 1'b1;
    repeat (2) @(negedge clk);
    snap = {busy, done, end_addr, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.rf_read_addr, bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data};
    checks++;
    if (snap !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", snap); end
    init_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy %b mem_req %b exp 0 0", busy, bus.mem_req);
    end
  endtask

  task automatic test_stm_basic();
    run_xfer(1'b0, 16'h0016, 32'h100, 4'd7, -1, 0, 0, 0);
    checks++;
    if (done_cyc != 4 + WB) begin errors++; $display("FAIL stm_done_cycle got %0d exp %0d", done_cyc, 4 + WB); end
    checks++;
    if (acc_addr.size() != 3) begin errors++; $display("FAIL stm_count got %0d exp 3", acc_addr.size()); end
    else begin
      checks++;
      if (acc_addr[0] !== 32'h100 || acc_addr[1] !== 32'h104 || acc_addr[2] !== 32'h108) begin
        errors++; $display("FAIL stm_addrs got %h %h %h exp 100 104 108", acc_addr[0], acc_addr[1], acc_addr[2]);
      end
      checks++;
      if (acc_data[0] !== pre_regs[1] || acc_data[1] !== pre_regs[2] || acc_data[2] !== pre_regs[4]) begin
        errors++; $display("FAIL stm_data got %h %h %h exp %h %h %h", acc_data[0], acc_data[1], acc_data[2],
                           pre_regs[1], pre_regs[2], pre_regs[4]);
      end
      checks++;
      if (acc_we[0] !== 1'b1 || acc_we[2] !== 1'b1) begin errors++; $display("FAIL stm_we got %b %b exp 1 1", acc_we[0], acc_we[2]); end
    end
    checks++;
    if (end_addr !== 32'h10C) begin errors++; $display("FAIL stm_end_addr got %h exp 10c", end_addr); end
  endtask

  task automatic test_ldm_basic();
    run_xfer(1'b1, 16'h8001, 32'h200, 4'd3, -1, 0, 0, 0);
    checks++;
    if (regs[0] !== 32'hA5A5_0200) begin errors++; $display("FAIL ldm_r0 got %h exp a5a50200", regs[0]); end
    checks++;
    if (regs[15] !== 32'hA5A5_0204) begin errors++; $display("FAIL ldm_r15 got %h exp a5a50204", regs[15]); end
    checks++;
    if (wr_addr.size() != 2 + WB) begin errors++; $display("FAIL ldm_write_pulses got %0d exp %0d", wr_addr.size(), 2 + WB); end
    checks++;
    if (done_cyc != 3 + WB) begin errors++; $display("FAIL ldm_done_cycle got %0d exp %0d", done_cyc, 3 + WB); end
  endtask

  task automatic test_stall();
    logic [15:0] list = 16'($urandom) | 16'h0101;
    int k = popc(list);
    run_xfer(1'b0, list, $urandom, 4'($urandom), 1, 3, 0, 0);
    checks++;
    if (stalls != 3) begin errors++; $display("FAIL stall_cycles got %0d exp 3", stalls); end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", unstable); end
    checks++;
    if (done_cyc != 1 + k + 3 + WB) begin errors++; $display("FAIL stall_done got %0d exp %0d", done_cyc, 1 + k + 3 + WB); end
  endtask

  task automatic test_wrap();
    run_xfer(1'b0, 16'h0000, 32'hFFFF_FFFC, 4'd5, -1, 0, 1, 0);
    checks++;
    if (req_cycles != 0) begin errors++; $display("FAIL empty_no_traffic got %0d req cycles exp 0", req_cycles); end
    checks++;
    if (done_cyc != 1 + WB) begin errors++; $display("FAIL empty_done got %0d exp %0d", done_cyc, 1 + WB); end
    checks++;
    if (end_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL empty_end_addr got %h exp fffffffc", end_addr); end
    run_xfer(1'b1, 16'hFFFF, 32'hFFFF_FFFC, 4'd0, -1, 0, 0, 0);
    checks++;
    if (acc_addr.size() != 16) begin errors++; $display("FAIL full_count got %0d exp 16", acc_addr.size()); end
    else begin
      checks++;
      if (acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0 || acc_addr[15] !== 32'h38) begin
        errors++; $display("FAIL full_wrap got %h %h %h exp fffffffc 0 38", acc_addr[0], acc_addr[1], acc_addr[15]);
      end
    end
    checks++;
    if (end_addr !== 32'h3C) begin errors++; $display("FAIL full_end_addr got %h exp 3c", end_addr); end
    checks++;
    if (done_cyc != 17 + WB) begin errors++; $display("FAIL full_done got %0d exp %0d", done_cyc, 17 + WB); end
  endtask

  task automatic test_wb();
    logic [31:0] base = $urandom & 32'h0FFF_FFF0;
    logic [31:0] exp_r2;
`ifdef BLOCK_XFER_WB_EN
    exp_r2 = base + 32'h8;
`else
    exp_r2 = 32'hA5A5_0004 + base;
`endif
    run_xfer(1'b1, 16'h0006, base, 4'd2, -1, 0, 0, 0);
    checks++;
    if (regs[1] !== 32'hA5A5_0000 + base) begin errors++; $display("FAIL wb_r1 got %h exp %h", regs[1], 32'hA5A5_0000 + base); end
    checks++;
    if (regs[2] !== exp_r2) begin errors++; $display("FAIL wb_r2 got %h exp %h", regs[2], exp_r2); end
    checks++;
    if (done_cyc != 3 + WB) begin errors++; $display("FAIL wb_done got %0d exp %0d", done_cyc, 3 + WB); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    @(negedge clk);
    start = 1'b1; is_load = 1'b0; reg_list = 16'h00F0; base_addr = $urandom; base_reg = 4'd9;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); bus.mem_ack = 1'b1;
    @(negedge clk); bus.mem_ack = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_second_req got %b exp 1", bus.mem_req); end
    rst = 1'b0;
    #1;
    snap = {busy, done, end_addr, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.rf_read_addr, bus.rf_write_enable, bus.rf_write_addr, bus.rf_write_data};
    checks++;
    if (snap !== '0) begin errors++; $display("FAIL mid_reset_outputs got %h exp 0", snap); end
    repeat (3) begin
      @(negedge clk);
      if (bus.mem_req !== 1'b0 || bus.rf_write_enable !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL mid_reset_strobes got %0d exp 0", stray); end
    rst = 1'b1;
    run_xfer(1'b1, 16'h0C30, 32'h4000, 4'd1, -1, 0, 0, 0);
    checks++;
    if (done_cyc != 5 + WB) begin errors++; $display("FAIL post_reset_done got %0d exp %0d", done_cyc, 5 + WB); end
    checks++;
    if (end_addr !== 32'h4010) begin errors++; $display("FAIL post_reset_end got %h exp 4010", end_addr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      logic ld = 1'($urandom);
      int sel = $urandom_range(0, 5);
      logic [15:0] list = (sel == 0) ? 16'h0 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      logic [31:0] base = $urandom;
      logic [3:0] breg = 4'($urandom);
      int k = popc(list);
      int j = 0, mism = 0;
      run_xfer(ld, list, base, breg, -1, 0, 1, 1);
      checks++;
      if (start_busy !== 1'b0) begin errors++; $display("FAIL rnd%0d accept_busy got %b exp 0", n, start_busy); end
      checks++;
      if (done_cyc != 1 + k + stalls + WB) begin
        errors++; $display("FAIL rnd%0d done got %0d exp %0d", n, done_cyc, 1 + k + stalls + WB);
      end
      checks++;
      if (busy_bad != 0 || unstable != 0) begin
        errors++; $display("FAIL rnd%0d busy_gaps %0d unstable %0d exp 0 0", n, busy_bad, unstable);
      end
      checks++;
      if (acc_addr.size() != k) begin errors++; $display("FAIL rnd%0d count got %0d exp %0d", n, acc_addr.size(), k); end
      else begin
        for (int i = 0; i < 16; i++) begin
          if (list[i]) begin
            checks++;
            if (acc_addr[j] !== (base & 32'hFFFF_FFFC) + 32'(4 * j) || acc_we[j] !== !ld ||
                (!ld && acc_data[j] !== pre_regs[i])) begin
              errors++;
              $display("FAIL rnd%0d access%0d got a=%h we=%b d=%h exp a=%h we=%b d=%h", n, j, acc_addr[j],
                       acc_we[j], acc_data[j], (base & 32'hFFFF_FFFC) + 32'(4 * j), !ld, pre_regs[i]);
            end
            j++;
          end
        end
      end
      checks++;
      if (end_addr !== model_end(list, base)) begin
        errors++; $display("FAIL rnd%0d end_addr got %h exp %h", n, end_addr, model_end(list, base));
      end
      checks++;
      if (wr_addr.size() != (ld ? k : 0) + WB) begin
        errors++; $display("FAIL rnd%0d writes got %0d exp %0d", n, wr_addr.size(), (ld ? k : 0) + WB);
      end
      for (int i = 0; i < 16; i++) if (regs[i] !== ref_regs[i]) mism++;
      checks++;
      if (mism != 0) begin errors++; $display("FAIL rnd%0d regfile got %0d differing regs exp 0", n, mism); end
    end
  endtask

  initial begin
    test_reset();
    test_stm_basic();
    test_ldm_basic();
    test_stall();
    test_wrap();
    test_wb();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
